// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, 3-sample majority vote per bit,
// one-cycle byte-valid and framing-error strobes.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   clk_cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shift_reg, shift_n;
  logic            samp_a, samp_a_n, samp_b, samp_b_n;
  logic            dv_n, ferr_n;
  logic [7:0]      byte_n;
  logic            vote, last, at_vote;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Rx_Byte   <= '0;
      o_Busy      <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= cnt_n;
      bit_idx     <= bit_n;
      shift_reg   <= shift_n;
      samp_a      <= samp_a_n;
      samp_b      <= samp_b_n;
      o_Rx_DV     <= dv_n;
      o_Frame_Err <= ferr_n;
      o_Rx_Byte   <= byte_n;
      o_Busy      <= (state_n != IDLE);
    end
  end

  // Samples at H-1 and H are held; the third is rx_s itself on the vote cycle H+1.
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign last    = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign at_vote = (clk_cnt == CW'(H + 1));

  always_comb begin
    state_n  = state;
    cnt_n    = clk_cnt;
    bit_n    = bit_idx;
    shift_n  = shift_reg;
    samp_a_n = (clk_cnt == CW'(H - 1)) ? rx_s : samp_a;
    samp_b_n = (clk_cnt == CW'(H))     ? rx_s : samp_b;
    dv_n     = 1'b0;
    ferr_n   = 1'b0;
    byte_n   = o_Rx_Byte;

    if (state != IDLE) begin
      cnt_n = last ? '0 : clk_cnt + CW'(1);
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
          cnt_n   = CW'(1);
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (last) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (at_vote) begin
          shift_n[bit_idx] = vote;
        end
        if (last) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      // Leave at mid stop bit so a slightly fast transmitter's next start edge is caught.
      STOP: begin
        if (at_vote) begin
          cnt_n = '0;
          if (vote) begin
            state_n = IDLE;
            dv_n    = 1'b1;
            byte_n  = shift_reg;
          end else begin
            state_n = WAIT_HIGH;
            ferr_n  = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
